// File: rtl/sprite_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sprite_rom_arbiter
// Function : Round-robin burst arbiter sharing one sprite ROM between two
//            fetchers, with a tagged return path for the read data.
// Revision : 1.0 - initial release
// ============================================================================
module sprite_rom_arbiter #(
    parameter int ADDR_W    = 15,
    parameter int DATA_W    = 4,
    parameter int BURST_LEN = 8,
    parameter int ROM_LAT   = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rom_rd,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic              busy
);

    localparam int                BEAT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BURST = 1'b1;

    logic [0:0]        r_state;
    logic [0:0]        w_next_state;
    logic [BEAT_W-1:0] r_beat;
    logic [ADDR_W-1:0] r_base;
    logic              r_owner;
    logic              r_last;
    logic [ROM_LAT-1:0] r_pipe_v;
    logic [ROM_LAT-1:0] r_pipe_o;

    logic w_any_req;
    logic w_winner;

    // Owner encoding: 0 = player 1, 1 = player 2. On contention the player
    // that did not win last time takes the ROM.
    assign w_any_req = req0 | req1;
    assign w_winner  = (req0 & req1) ? ~r_last : req1;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_any_req)           w_next_state = S_BURST;
            S_BURST: if (r_beat == LAST_BEAT) w_next_state = S_IDLE;
            default:                          w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (r_state == S_BURST);
        rom_rd   = busy;
        rom_addr = busy ? (r_base + ADDR_W'(r_beat)) : '0;
        gnt0     = busy && (r_beat == '0) && !r_owner;
        gnt1     = busy && (r_beat == '0) &&  r_owner;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_beat  <= '0;
            r_base  <= '0;
            r_owner <= 1'b0;
            r_last  <= 1'b1;
        end else if (r_state == S_IDLE) begin
            r_beat <= '0;
            if (w_any_req) begin
                r_base  <= w_winner ? addr1 : addr0;
                r_owner <= w_winner;
                r_last  <= w_winner;
            end
        end else begin
            r_beat <= (r_beat == LAST_BEAT) ? '0 : r_beat + BEAT_W'(1);
        end
    end

    // Return tags travel alongside the ROM latency, independent of the FSM,
    // so a new burst can start while the previous one is still draining.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_pipe_v <= '0;
            r_pipe_o <= '0;
        end else begin
            for (int i = ROM_LAT - 1; i > 0; i--) begin
                r_pipe_v[i] <= r_pipe_v[i-1];
                r_pipe_o[i] <= r_pipe_o[i-1];
            end
            r_pipe_v[0] <= rom_rd;
            r_pipe_o[0] <= r_owner;
        end
    end

    assign rvalid0 = r_pipe_v[ROM_LAT-1] & ~r_pipe_o[ROM_LAT-1];
    assign rvalid1 = r_pipe_v[ROM_LAT-1] &  r_pipe_o[ROM_LAT-1];
    assign rdata   = rom_data;

endmodule
`default_nettype wire

// File: tb/tb_sprite_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sprite_rom_arbiter
// Function : Directed self-checking bench for sprite_rom_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sprite_rom_arbiter;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [14:0] addr0 = '0, addr1 = '0;
    logic        gnt0, gnt1, rom_rd, rvalid0, rvalid1, busy;
    logic [14:0] rom_addr;
    logic [3:0]  rom_data, rdata;

    logic        req0_6 = 1'b0, req1_6 = 1'b0;
    logic [14:0] addr0_6 = '0, addr1_6 = '0;
    logic        gnt0_6, gnt1_6, rom_rd_6, rvalid0_6, rvalid1_6, busy_6;
    logic [14:0] rom_addr_6;
    logic [3:0]  rom_data_6, rdata_6;

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    sprite_rom_arbiter u_dut (
        .Clk(Clk), .Reset(Reset),
        .req0(req0), .addr0(addr0), .req1(req1), .addr1(addr1),
        .gnt0(gnt0), .gnt1(gnt1), .rom_rd(rom_rd), .rom_addr(rom_addr),
        .rom_data(rom_data), .rdata(rdata),
        .rvalid0(rvalid0), .rvalid1(rvalid1), .busy(busy)
    );

    sprite_rom_arbiter #(.ADDR_W(15), .DATA_W(4), .BURST_LEN(1), .ROM_LAT(4)) u_dut6 (
        .Clk(Clk), .Reset(Reset),
        .req0(req0_6), .addr0(addr0_6), .req1(req1_6), .addr1(addr1_6),
        .gnt0(gnt0_6), .gnt1(gnt1_6), .rom_rd(rom_rd_6), .rom_addr(rom_addr_6),
        .rom_data(rom_data_6), .rdata(rdata_6),
        .rvalid0(rvalid0_6), .rvalid1(rvalid1_6), .busy(busy_6)
    );

    function automatic logic [3:0] rom_fn(input logic [14:0] a);
        return a[3:0] ^ a[7:4] ^ a[11:8] ^ {1'b0, a[14:12]};
    endfunction

    // ROM models: data appears ROM_LAT cycles after the address
    logic [14:0] ad2 [2];
    logic [14:0] ad4 [4];
    always @(posedge Clk) begin
        ad2[0] <= rom_addr;
        ad2[1] <= ad2[0];
        ad4[0] <= rom_addr_6;
        for (int i = 1; i < 4; i++) ad4[i] <= ad4[i-1];
    end
    assign rom_data   = rom_fn(ad2[1]);
    assign rom_data_6 = rom_fn(ad4[3]);

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
    endtask

    initial begin
        logic [14:0] ea;
        logic        ev0, ev1;
        int          b, p;

        // Test 1: single P1 burst and reset state
        do_reset();
        chk("rst_busy", busy, 0);
        chk("rst_rom_rd", rom_rd, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_gnt", {gnt1, gnt0}, 0);
        chk("rst_rvalid", {rvalid1, rvalid0}, 0);
        req0 = 1'b1; addr0 = 15'h0100;
        tick();
        req0 = 1'b0;
        for (int k = 0; k < 12; k++) begin
            ea = (k < 8) ? 15'h0100 + 15'(k) : 15'h0000;
            chk("t1_gnt0", gnt0, (k == 0));
            chk("t1_gnt1", gnt1, 0);
            chk("t1_rom_rd", rom_rd, (k < 8));
            chk("t1_busy", busy, (k < 8));
            chk("t1_rom_addr", rom_addr, ea);
            chk("t1_rvalid0", rvalid0, (k >= 2 && k < 10));
            chk("t1_rvalid1", rvalid1, 0);
            if (k >= 2 && k < 10) chk("t1_rdata", rdata, rom_fn(15'h0100 + 15'(k - 2)));
            tick();
        end

        // Test 2: both requests held -> alternating grants every 9 cycles
        do_reset();
        req0 = 1'b1; addr0 = 15'h0200;
        req1 = 1'b1; addr1 = 15'h0300;
        tick();
        for (int j = 0; j < 38; j++) begin
            b = j / 9;
            p = j % 9;
            chk("t2_gnt0", gnt0, (p == 0) && (b % 2 == 0));
            chk("t2_gnt1", gnt1, (p == 0) && (b % 2 == 1));
            chk("t2_busy", busy, (p < 8));
            ea = (p < 8) ? (((b % 2 == 0) ? 15'h0200 : 15'h0300) + 15'(p)) : 15'h0000;
            chk("t2_rom_addr", rom_addr, ea);
            ev0 = (j >= 2) && ((j - 2) % 9 < 8) && (((j - 2) / 9) % 2 == 0);
            ev1 = (j >= 2) && ((j - 2) % 9 < 8) && (((j - 2) / 9) % 2 == 1);
            chk("t2_rvalid0", rvalid0, ev0);
            chk("t2_rvalid1", rvalid1, ev1);
            chk("t2_no_overlap", rvalid0 & rvalid1, 0);
            tick();
        end
        req0 = 1'b0; req1 = 1'b0;

        // Test 3: P2 burst wrapping the address space
        do_reset();
        req1 = 1'b1; addr1 = 15'h7FFC;
        tick();
        req1 = 1'b0;
        chk("t3_gnt1", gnt1, 1);
        chk("t3_gnt0", gnt0, 0);
        for (int k = 0; k < 8; k++) begin
            ea = 15'h7FFC + 15'(k);
            chk("t3_rom_addr", rom_addr, ea);
            tick();
        end
        tick();
        chk("t3_rvalid1_tail", rvalid1, 1);
        chk("t3_rdata_tail", rdata, rom_fn(15'h0003));

        // Test 4: reset in beat 3 of a P1 burst
        do_reset();
        req0 = 1'b1; addr0 = 15'h0400;
        tick();
        req0 = 1'b0;
        tick(); tick(); tick();
        chk("t4_beat3_addr", rom_addr, 15'h0403);
        chk("t4_beat3_rvalid0", rvalid0, 1);
        Reset = 1'b1;
        #1;
        chk("t4_async_busy", busy, 0);
        chk("t4_async_rom_rd", rom_rd, 0);
        chk("t4_async_rom_addr", rom_addr, 0);
        chk("t4_async_rvalid0", rvalid0, 0);
        tick();
        Reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("t4_post_rvalid0", rvalid0, 0);
            chk("t4_post_busy", busy, 0);
            tick();
        end
        req0 = 1'b1; req1 = 1'b1; addr1 = 15'h0500;
        tick();
        chk("t4_first_gnt0", gnt0, 1);
        chk("t4_first_gnt1", gnt1, 0);
        req0 = 1'b0; req1 = 1'b0;

        // Test 5: req0 held alone -> P1 grant every 9 cycles
        do_reset();
        req0 = 1'b1; addr0 = 15'h0500;
        for (int j = 0; j < 27; j++) begin
            tick();
            chk("t5_gnt0", gnt0, (j % 9 == 0));
            chk("t5_gnt1", gnt1, 0);
            chk("t5_busy", busy, (j % 9 < 8));
        end
        req0 = 1'b0;

        // Test 6: ROM_LAT=4, BURST_LEN=1 instance
        do_reset();
        req0_6 = 1'b1; addr0_6 = 15'h1234;
        tick();
        req0_6 = 1'b0;
        chk("t6_gnt0", gnt0_6, 1);
        chk("t6_rom_addr", rom_addr_6, 15'h1234);
        for (int k = 0; k < 7; k++) begin
            chk("t6_rom_rd", rom_rd_6, (k == 0));
            chk("t6_rvalid0", rvalid0_6, (k == 4));
            chk("t6_rvalid1", rvalid1_6, 0);
            if (k == 4) chk("t6_rdata", rdata_6, rom_fn(15'h1234));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
